// File: rtl/instr_controller.sv
// instr_controller: instruction register, decoder and multicycle control FSM for the datapath
module instr_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);
    typedef enum logic [2:0] {
        S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_ALU, S_WR_REG, S_WR_IMM
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op, sh;
    logic       mov_imm, mov_reg, alu_ins, mvn, cmp;

    assign opcode  = ir_q[15:13];
    assign op      = ir_q[12:11];
    assign rn      = ir_q[10:8];
    assign rd      = ir_q[7:5];
    assign sh      = ir_q[4:3];
    assign rm      = ir_q[2:0];
    assign mov_imm = opcode == 3'b110 && op == 2'b10;
    assign mov_reg = opcode == 3'b110 && op == 2'b00;
    assign alu_ins = opcode == 3'b101;
    assign mvn     = alu_ins && op == 2'b11;
    assign cmp     = alu_ins && op == 2'b01;

    assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
    assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};
    assign bsel   = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_WAIT;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ir_d     = (state_q == S_WAIT && load) ? in : ir_q;
        w        = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        vsel     = 2'b00;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        shift    = 2'b00;
        ALUop    = 2'b00;
        case (state_q)
            S_WAIT: begin
                w       = 1'b1;
                state_d = s ? S_DECODE : S_WAIT;
            end
            // illegal encodings fall back to WAIT without touching any strobe
            S_DECODE: state_d = mov_imm ? S_WR_IMM :
                                (mov_reg || mvn) ? S_GET_B :
                                alu_ins ? S_GET_A : S_WAIT;
            S_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
                state_d = S_GET_B;
            end
            S_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
                state_d = S_ALU;
            end
            S_ALU: begin
                shift   = sh;
                ALUop   = mov_reg ? 2'b00 : op;
                asel    = mov_reg || mvn;
                loads   = cmp;
                loadc   = !cmp;
                state_d = cmp ? S_WAIT : S_WR_REG;
            end
            S_WR_REG: begin
                writenum = rd;
                write    = 1'b1;
                state_d  = S_WAIT;
            end
            S_WR_IMM: begin
                writenum = rn;
                vsel     = 2'b10;
                write    = 1'b1;
                state_d  = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end
endmodule

// File: tb/tb_instr_controller.sv
// tb_instr_controller: scoreboard bench; per-cycle expected outputs from an instruction-level model
module tb_instr_controller;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s = 1'b0;
    logic        load = 1'b0;
    logic [15:0] in = 16'h0000;
    logic        w, write, loada, loadb, loadc, loads, asel, bsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel, shift, ALUop;
    logic [15:0] sximm8, sximm5;

    instr_controller dut (
        .clk(clk), .reset(reset), .s(s), .load(load), .in(in), .w(w),
        .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
        .sximm8(sximm8), .sximm5(sximm5)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        w;
        logic [2:0]  rn;
        logic [2:0]  wn;
        logic        wr;
        logic [1:0]  vsel;
        logic        la, lb, lc, ls, asel, bsel;
        logic [1:0]  sh, aop;
        logic [15:0] x8, x5;
    } vec_t;

    typedef enum {K_WAIT, K_DEC, K_A, K_B, K_ALU, K_WR, K_IMM} kind_t;

    vec_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] ir_m = 16'h0000;

    // Expected outputs for one cycle of an instruction, from the instruction semantics
    function automatic vec_t mk(kind_t k, logic [15:0] ir);
        vec_t v = '0;
        logic is_movr = ir[15:13] == 3'b110 && ir[12:11] == 2'b00;
        logic is_mvn  = ir[15:13] == 3'b101 && ir[12:11] == 2'b11;
        logic is_cmp  = ir[15:13] == 3'b101 && ir[12:11] == 2'b01;
        v.x8 = {{8{ir[7]}}, ir[7:0]};
        v.x5 = {{11{ir[4]}}, ir[4:0]};
        v.w  = (k == K_WAIT);
        if (k == K_A) begin v.rn = ir[10:8]; v.la = 1'b1; end
        if (k == K_B) begin v.rn = ir[2:0]; v.lb = 1'b1; end
        if (k == K_ALU) begin
            v.sh   = ir[4:3];
            v.aop  = is_movr ? 2'b00 : ir[12:11];
            v.asel = is_movr || is_mvn;
            v.ls   = is_cmp;
            v.lc   = !is_cmp;
        end
        if (k == K_WR) begin v.wn = ir[7:5]; v.wr = 1'b1; end
        if (k == K_IMM) begin v.wn = ir[10:8]; v.vsel = 2'b10; v.wr = 1'b1; end
        return v;
    endfunction

    function automatic void steps(logic [15:0] ir, output kind_t seq[$]);
        seq = {K_DEC};
        case ({ir[15:13], ir[12:11]})
            5'b110_10: seq = {K_DEC, K_IMM};
            5'b110_00, 5'b101_11: seq = {K_DEC, K_B, K_ALU, K_WR};
            5'b101_00, 5'b101_10: seq = {K_DEC, K_A, K_B, K_ALU, K_WR};
            5'b101_01: seq = {K_DEC, K_A, K_B, K_ALU};
            default: seq = {K_DEC};
        endcase
    endfunction

    always @(negedge clk) begin
        vec_t a, e;
        a = {w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
             asel, bsel, shift, ALUop, sximm8, sximm5};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs t=%0t ir_model=%h actual=%h required=%h", $time, ir_m, a, e);
            end
            checks++;
            if ($countones({write, loada, loadb, loadc, loads}) > 1) begin
                errors++;
                $display("FAIL strobe_onehot t=%0t actual=%b required=at most one", $time,
                         {write, loada, loadb, loadc, loads});
            end
        end
    end

    task automatic issue(input logic [15:0] instr, input int abort_at);
        kind_t seq[$];
        steps(instr, seq);
        in = instr; load = 1'b1; s = 1'b1;
        exp_q.push_back(mk(K_WAIT, ir_m));
        @(posedge clk); #1;
        ir_m = instr;
        for (int i = 0; i < seq.size(); i++) begin
            s = 1'($urandom); load = 1'($urandom); in = 16'($urandom);
            if (i == abort_at) reset = 1'b1;
            exp_q.push_back(mk(seq[i], ir_m));
            @(posedge clk); #1;
            if (reset) begin
                reset = 1'b0;
                ir_m = 16'h0000;
                break;
            end
        end
    endtask

    task automatic idle();
        logic [15:0] v = 16'($urandom);
        logic        l = 1'($urandom);
        s = 1'b0; load = l; in = v;
        exp_q.push_back(mk(K_WAIT, ir_m));
        @(posedge clk); #1;
        if (l) ir_m = v;
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] r = 16'($urandom);
        case ($urandom_range(0, 6))
            0: r[15:11] = 5'b110_10;
            1: r[15:11] = 5'b110_00;
            2, 3, 4, 5: r[15:13] = 3'b101;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        @(posedge clk); #1;
        reset = 1'b0;
        ir_m = 16'h0000;
        issue(16'hD007, -1);
        issue(16'hD1FE, -1);
        issue(16'hA148, -1);
        issue(16'hA801, -1);
        issue(16'hC062, -1);
        issue(16'hE000, -1);
        idle();
        issue(16'hA148, 2);
        issue(16'hD007, -1);
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) idle();
            issue(rand_instr(), ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1);
        end
        idle();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
